// File: rtl/gcd_rr_scheduler_pkg.sv
// Shared constants for the round-robin GCD scheduler: state encoding and digit sizing.
package gcd_rr_scheduler_pkg;

    localparam int DIGIT_W_DEF = 4;
    localparam int DIGIT_MOD   = 10;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ACK  = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD = 3'd4;

endpackage

// File: rtl/gcd_rr_scheduler_gcd_core.sv
// Iterative subtractive GCD engine: one step per cycle.
// start loads the operand pair; done/res are combinational and valid while the
// pair has converged (either side zero, or both equal). abort drops the job.
module gcd_core #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    output logic         done,
    output logic [W-1:0] res
);

    logic         running;
    logic [W-1:0] x;
    logic [W-1:0] y;

    // Termination test and result selection; gcd(0,0) falls out as 0.
    always_comb begin
        done = running && ((x == '0) || (y == '0) || (x == y));
        res  = (x == '0) ? y : x;
    end

    // Operand registers: load on start, otherwise subtract smaller from larger.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b0;
            x       <= '0;
            y       <= '0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            x       <= x_in;
            y       <= y_in;
        end else if (running) begin
            if (done) begin
                running <= 1'b0;
            end else if (x > y) begin
                x <= x - y;
            end else begin
                y <= y - x;
            end
        end
    end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Two-requester round-robin front end for a shared GCD engine.
// Handshake: a requester raises req[i] and holds it (operands stable) until it
// sees the one-cycle ack[i]; dropping req[i] before ack abandons the job. grant
// is one-hot from LOAD through ACK. After each ack a NUM-cycle hold window
// blocks new grants.
module gcd_rr_scheduler
    import gcd_rr_scheduler_pkg::*;
#(
    parameter int NUM     = 50_000_000,
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [DIGIT_W-1:0] a0,
    input  logic [DIGIT_W-1:0] b0,
    input  logic [DIGIT_W-1:0] a1,
    input  logic [DIGIT_W-1:0] b1,
    output logic [1:0]         grant,
    output logic [1:0]         ack,
    output logic [DIGIT_W-1:0] result,
    output logic               result_id,
    output logic               busy,
    output logic [DIGIT_W-1:0] data_out
);

    localparam int CW = $clog2(NUM) + 1;
    localparam logic [CW-1:0] HOLD_INIT = CW'((NUM > 0) ? NUM - 1 : 0);
    localparam logic [DIGIT_W-1:0] MOD_V = DIGIT_W'(DIGIT_MOD);

    logic [STATE_W-1:0] state;
    logic               win;       // requester currently being served
    logic               rr_ptr;    // preferred requester when both ask
    logic [CW-1:0]      hold_cnt;

    logic               win_next;
    logic [DIGIT_W-1:0] sel_a;
    logic [DIGIT_W-1:0] sel_b;
    logic [DIGIT_W-1:0] red_a;
    logic [DIGIT_W-1:0] red_b;
    logic               core_start;
    logic               core_abort;
    logic               core_done;
    logic [DIGIT_W-1:0] core_res;
    logic               win_req;

    // Arbitration, operand selection with mod-10 reduction, core control.
    always_comb begin
        win_next   = (req == 2'b11) ? rr_ptr : req[1];
        sel_a      = win ? a1 : a0;
        sel_b      = win ? b1 : b0;
        red_a      = (sel_a >= MOD_V) ? sel_a - MOD_V : sel_a;
        red_b      = (sel_b >= MOD_V) ? sel_b - MOD_V : sel_b;
        win_req    = req[win];
        core_start = (state == ST_LOAD) && win_req;
        core_abort = (state == ST_RUN) && !win_req;
        busy       = (state != ST_IDLE);
        data_out   = result;
    end

    gcd_core #(.W(DIGIT_W)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .abort (core_abort),
        .x_in  (red_a),
        .y_in  (red_b),
        .done  (core_done),
        .res   (core_res)
    );

    // Scheduler FSM with grant/ack, result registers and hold-window counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant     <= 2'b00;
            ack       <= 2'b00;
            result    <= '0;
            result_id <= 1'b0;
            win       <= 1'b0;
            rr_ptr    <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            ack <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        win   <= win_next;
                        grant <= win_next ? 2'b10 : 2'b01;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!win_req) begin
                        grant <= 2'b00;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!win_req) begin
                        grant <= 2'b00;
                        state <= ST_IDLE;
                    end else if (core_done) begin
                        ack       <= win ? 2'b10 : 2'b01;
                        result    <= core_res;
                        result_id <= win;
                        rr_ptr    <= ~win;
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    grant <= 2'b00;
                    if (NUM > 0) begin
                        hold_cnt <= HOLD_INIT;
                        state    <= ST_HOLD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler with NUM=4: transaction-level model compared every
// cycle, plus directed literal expectations for latency, results and resets.
module tb_gcd_rr_scheduler;

    localparam int NUM = 4;
    localparam int W   = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   grant, ack;
    logic [W-1:0] result, data_out;
    logic         result_id, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic check_en = 1'b0;

    gcd_rr_scheduler #(.NUM(NUM), .DIGIT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .grant     (grant),
        .ack       (ack),
        .result    (result),
        .result_id (result_id),
        .busy      (busy),
        .data_out  (data_out)
    );

    // Clock and cycle index (cycle k lies between posedge k and posedge k+1).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int gcd_ref(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Number of RUN cycles: one per subtraction plus the terminating cycle.
    function automatic int run_cycles(input int x, input int y);
        int n = 1;
        while (!(x == 0 || y == 0 || x == y)) begin
            if (x > y) x = x - y;
            else       y = y - x;
            n++;
        end
        return n;
    endfunction

    int         m_phase = 0;   // 0 idle, 1 serving (LOAD..ACK), 2 hold window
    int         m_win = 0, m_t = 0, m_runs = 0, m_gcd = 0, m_hold = 0, m_ptr = 0;
    logic [1:0] exp_grant = 2'b00, exp_ack = 2'b00;
    logic [W-1:0] exp_result = '0;
    logic       exp_id = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_t = 0; m_hold = 0;
            exp_grant = 2'b00; exp_ack = 2'b00; exp_result = '0; exp_id = 1'b0;
        end else begin
            exp_ack = 2'b00;
            case (m_phase)
                0: if (req != 2'b00) begin
                    m_win     = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
                    exp_grant = (m_win == 1) ? 2'b10 : 2'b01;
                    m_phase   = 1;
                    m_t       = 0;
                end
                1: begin
                    if (m_t <= m_runs || m_t == 0) begin
                        if (!req[m_win]) begin
                            m_phase = 0;
                            exp_grant = 2'b00;
                        end else if (m_t == 0) begin
                            m_runs = run_cycles(int'(m_win ? a1 : a0) % 10, int'(m_win ? b1 : b0) % 10);
                            m_gcd  = gcd_ref(int'(m_win ? a1 : a0) % 10, int'(m_win ? b1 : b0) % 10);
                            m_t = 1;
                        end else begin
                            if (m_t == m_runs) begin
                                exp_ack    = (m_win == 1) ? 2'b10 : 2'b01;
                                exp_result = W'(m_gcd);
                                exp_id     = (m_win == 1);
                                m_ptr      = 1 - m_win;
                            end
                            m_t++;
                        end
                    end else begin
                        exp_grant = 2'b00;
                        m_hold    = NUM;
                        m_phase   = (NUM > 0) ? 2 : 0;
                    end
                end
                default: begin
                    m_hold--;
                    if (m_hold == 0) m_phase = 0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("grant",     32'(grant),     32'(exp_grant));
            check("ack",       32'(ack),       32'(exp_ack));
            check("result",    32'(result),    32'(exp_result));
            check("result_id", 32'(result_id), 32'(exp_id));
            check("busy",      32'(busy),      32'(m_phase != 0));
            check("data_out",  32'(data_out),  32'(exp_result));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(output int ack_cyc, output logic [1:0] got_ack, output logic [W-1:0] got_res);
        ack_cyc = -1; got_ack = 2'b00; got_res = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                ack_cyc = cyc; got_ack = ack; got_res = result;
                return;
            end
        end
        check("ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle(output int idle_cyc);
        idle_cyc = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_cyc = cyc;
                return;
            end
        end
        check("idle_timeout", 32'(0), 32'(1));
    endtask

    // Apply reset for one edge from a negedge and check all outputs at the next negedge.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        @(negedge clk);
        check(name, 32'({grant, ack, result, result_id, busy, data_out}), 32'(0));
        rst_n = 1'b1;
        req   = 2'b00;
    endtask

    // Single request, called at a negedge while idle.
    task automatic do_single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int exp_res, input int exp_runs);
        int t, ack_cyc, idle_cyc;
        logic [1:0] got_ack;
        logic [W-1:0] got_res;
        if (id == 0) begin a0 = a; b0 = b; req = 2'b01; end
        else         begin a1 = a; b1 = b; req = 2'b10; end
        t = cyc;
        @(negedge clk);
        check("grant_t1", 32'(grant), (id == 0) ? 32'h1 : 32'h2);
        wait_ack(ack_cyc, got_ack, got_res);
        check("ack_vec", 32'(got_ack), (id == 0) ? 32'h1 : 32'h2);
        check("ack_result", 32'(got_res), 32'(exp_res));
        check("ack_latency", 32'(ack_cyc - t), 32'(2 + exp_runs));
        req = 2'b00;
        wait_idle(idle_cyc);
        check("idle_after_hold", 32'(idle_cyc - ack_cyc), 32'(1 + NUM));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ack_cyc, idle_cyc;
        logic [1:0] got_ack;
        logic [W-1:0] got_res;

        rst_n = 1'b0; req = 2'b11;
        a0 = 4'd6; b0 = 4'd9; a1 = 4'd8; b1 = 4'd4;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        check("reset_outputs", 32'({grant, ack, result, result_id, busy, data_out}), 32'(0));
        rst_n = 1'b1; req = 2'b00;
        @(negedge clk);

        // Basic transaction: (6,4) -> 2, three RUN cycles.
        do_single(0, 4'd6, 4'd4, 2, 3);
        check("result_id_t1", 32'(result_id), 32'(0));

        // Both requesting from a fresh pointer: service 0,1,0.
        do_reset("reset_before_rr");
        a0 = 4'd6; b0 = 4'd9; a1 = 4'd8; b1 = 4'd4;
        req = 2'b11;
        wait_ack(ack_cyc, got_ack, got_res);
        check("rr_ack1", 32'({got_ack, got_res}), 32'({2'b01, 4'd3}));
        wait_ack(ack_cyc, got_ack, got_res);
        check("rr_ack2", 32'({got_ack, got_res}), 32'({2'b10, 4'd4}));
        wait_ack(ack_cyc, got_ack, got_res);
        check("rr_ack3", 32'({got_ack, got_res}), 32'({2'b01, 4'd3}));
        req = 2'b00;
        wait_idle(idle_cyc);

        // Edge operands.
        do_single(0, 4'd0,  4'd0, 0, 1);
        do_single(0, 4'd0,  4'd7, 7, 1);
        do_single(0, 4'd9,  4'd1, 1, 9);
        do_single(0, 4'd12, 4'd8, 2, 4);
        do_single(1, 4'd15, 4'd10, 5, 1);
        check("result_id_edge", 32'(result_id), 32'(1));

        // Abandon: requester 0 drops in its second RUN cycle; requester 1 then served.
        do_reset("reset_before_abandon");
        a0 = 4'd6; b0 = 4'd4; a1 = 4'd9; b1 = 4'd6;
        req = 2'b11;
        repeat (3) @(negedge clk);
        req = 2'b10;
        wait_ack(ack_cyc, got_ack, got_res);
        check("abandon_ack", 32'({got_ack, got_res}), 32'({2'b10, 4'd3}));
        req = 2'b00;
        wait_idle(idle_cyc);

        // Reset inside the hold window.
        a0 = 4'd6; b0 = 4'd4; req = 2'b01;
        wait_ack(ack_cyc, got_ack, got_res);
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("busy_in_hold", 32'(busy), 32'(1));
        do_reset("reset_in_hold");

        // Reset during RUN.
        @(negedge clk);
        a0 = 4'd9; b0 = 4'd1; req = 2'b01;
        repeat (4) @(negedge clk);
        check("grant_in_run", 32'(grant), 32'(1));
        do_reset("reset_in_run");
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
